mem_stream_reader: RTL and testbench
====================================

Name: mem_stream_reader

Overview:
- Read initiator for one port of the team's true dual-port block RAM.
- The RAM port has 1-cycle read latency, READ_FIRST mode, and no output register.
- Accepts a (base address, length) command, issues sequential reads on the RAM port, and presents the returned words on a valid/ready stream with full backpressure support.
- Sits between the RAM port and the systolic/vector datapath consumers; sustains 1 word/cycle when the sink is always ready.

Parameters:
- DATA_WIDTH, 32, RAM word width.
- ADDR_WIDTH, 13, RAM address width (depth 2^ADDR_WIDTH).
- LEN_WIDTH, ADDR_WIDTH+1, command length width; allows a full-depth transfer.

Ports:
- clk  in  1  single clock; also drives the attached RAM port clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when valid&ready.
- cmd_addr  in  ADDR_WIDTH  first word address.
- cmd_len  in  LEN_WIDTH  word count (0 allowed).
- mem_en  out  1  RAM port enable.
- mem_we  out  1  RAM write enable; constant 0.
- mem_addr  out  ADDR_WIDTH  RAM address.
- mem_dout  in  DATA_WIDTH  RAM read data, valid 1 cycle after mem_en.
- m_valid  out  1  stream word valid.
- m_ready  in  1  stream sink ready.
- m_data  out  DATA_WIDTH  stream word.
- m_last  out  1  marks the final word of a command.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse when a command completes.

Behaviour:
- Reset values: cmd_ready=1, mem_en=0, mem_we=0, mem_addr=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0. State=IDLE, buffer empty, in-flight flag cleared.
- States:
  - IDLE: cmd_ready=1. On accept with len>0: latch the address counter and the remaining count, then go to ISSUE. On accept with len=0: no reads, done=1 on the next cycle, stay IDLE.
  - ISSUE: cmd_ready=0. Issue one read per cycle when credit allows. When the final read is issued, go to DRAIN.
  - DRAIN: wait until the in-flight flag is 0 and the buffer is empty. Then pulse done, set busy=0 on the same edge, and go to IDLE.
- Read issue:
  - mem_en = (state==ISSUE) && (remaining>0) && credit.
  - mem_addr = address counter register.
  - On each issue: address counter +1 modulo 2^ADDR_WIDTH (wraps 2^ADDR_WIDTH-1 -> 0) and remaining -1.
- Credit:
  - Output buffer is exactly 2 entries.
  - credit = (occupancy + inflight - pop) < 2, where pop = m_valid && m_ready.
  - This is a combinational path from m_ready to mem_en and is permitted.
  - The buffer never overflows. A registered in-flight bit (set the cycle after mem_en) captures mem_dout into the buffer.
- Stream:
  - m_valid = buffer non-empty; m_data/m_last come from the head entry.
  - Once m_valid is asserted, m_data and m_last hold stable until the word is accepted.
  - m_last is tagged at issue time on the read where remaining==1.
- Latency: command accepted at edge N -> first mem_en in cycle N+1 -> first m_valid in cycle N+2 (with m_ready=1).
- Simultaneous capture and pop: both take effect; occupancy is unchanged.
- done rises one cycle after the m_last word handshake. The next command can be accepted in the cycle done is high.
- Reset mid-operation:
  - Everything returns to reset values immediately.
  - The read returned in the cycle after reset deasserts is discarded (in-flight flag already cleared).
  - No done pulse is generated for the aborted command.

Optional Feature:
- Macro: MEM_STREAM_READER_PERF_EN.
- Defined:
  - Adds output perf_stall_cycles (32 bits).
  - Counts cycles in ISSUE with remaining>0 and credit=0.
  - Saturates at 0xFFFFFFFF.
  - Clears to 0 on command accept and on reset.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- cmd_addr=0x010, len=4, m_ready=1, RAM preloaded mem[a]=a*3 -> mem_addr 0x010..0x013 on 4 consecutive cycles; m_data 0x30,0x33,0x36,0x39 on 4 consecutive cycles; m_last on 0x39; done 1 cycle after.
- Same command with m_ready toggling 1,0,0,1,0,1… -> no word lost or duplicated; m_data stable while stalled; at most 2 reads outstanding beyond pops.
- cmd_len=0 -> mem_en never asserted, m_valid stays 0, done pulses exactly once 1 cycle after accept.
- cmd_addr=8190, len=4 -> mem_addr sequence 8190, 8191, 0, 1; data order is preserved.
- rst asserted for 1 cycle after 2 of 8 words have been delivered -> all outputs reach reset values; the next command (addr=0x100, len=2) returns exactly mem[0x100] and mem[0x101].
- Back-to-back len=8 commands with m_ready=1 -> second command accepted on the done cycle. With MEM_STREAM_READER_PERF_EN: perf_stall_cycles=0 under m_ready=1, and equals the blocked-cycle count when m_ready is held 0 for 5 cycles.

Source files
------------

// File: rtl/mem_stream_reader.sv
// Sequential read initiator for one port of a 1-cycle-latency block RAM, streaming words out.
// Optional stall-cycle counter output when MEM_STREAM_READER_PERF_EN is defined.
module mem_stream_reader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
`ifdef MEM_STREAM_READER_PERF_EN
  output logic [31:0]           perf_stall_cycles,
`endif
  output logic                  done
);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic                  inflight_q, inflight_last_q;
  logic [DATA_WIDTH-1:0] buf_data_q [2];
  logic [1:0]            buf_last_q;
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            count_q, count_d;
  logic                  done_q, done_d;

  logic                  cmd_accept;
  logic                  buf_empty;
  logic                  has_remaining;
  logic                  pop, pop_buf, push;
  logic [2:0]            pending;
  logic                  credit;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  head_last;

  assign cmd_ready     = (state_q == StIdle);
  assign cmd_accept    = cmd_valid && cmd_ready;
  assign buf_empty     = (count_q == 2'd0);
  assign has_remaining = (remaining_q != '0);

  // With an empty buffer the returning RAM word is presented directly; if it is not
  // taken it is captured, so the head value stays stable across the stall.
  assign m_valid   = !buf_empty || inflight_q;
  assign head_data = buf_empty ? mem_dout : buf_data_q[rd_ptr_q];
  assign head_last = buf_empty ? inflight_last_q : buf_last_q[rd_ptr_q];
  assign m_data    = m_valid ? head_data : '0;
  assign m_last    = m_valid && head_last;

  assign pop     = m_valid && m_ready;
  assign pop_buf = pop && !buf_empty;
  assign push    = inflight_q && !(pop && buf_empty);
  assign count_d = count_q + 2'(push) - 2'(pop_buf);

  // Two-entry budget shared by stored words and the read still in the RAM pipeline.
  assign pending = 3'(count_q) + 3'(inflight_q) - 3'(pop);
  assign credit  = (pending < 3'd2);

  assign mem_en   = (state_q == StIssue) && has_remaining && credit;
  assign mem_we   = 1'b0;
  assign mem_addr = addr_q;
  assign busy     = (state_q != StIdle);
  assign done     = done_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_accept) begin
          if (cmd_len != '0) begin
            addr_d      = cmd_addr;
            remaining_d = cmd_len;
            state_d     = StIssue;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StIssue: begin
        if (mem_en) begin
          addr_d      = addr_q + ADDR_WIDTH'(1);
          remaining_d = remaining_q - LEN_WIDTH'(1);
          if (remaining_q == LEN_WIDTH'(1)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // No reads issue here, so an empty next-state buffer means the last word has left.
        if (count_d == 2'd0) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StIdle;
      addr_q          <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      inflight_q  <= mem_en;
      done_q      <= done_d;
      if (mem_en) begin
        inflight_last_q <= (remaining_q == LEN_WIDTH'(1));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        buf_data_q[i] <= '0;
      end
      buf_last_q <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      count_q <= count_d;
      if (push) begin
        buf_data_q[wr_ptr_q] <= mem_dout;
        buf_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop_buf) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

`ifdef MEM_STREAM_READER_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (cmd_accept) begin
      stall_q <= '0;
    end else if ((state_q == StIssue) && has_remaining && !credit && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_mem_stream_reader.sv
// Scoreboard bench for mem_stream_reader with a behavioural READ_FIRST RAM port model.
module tb_mem_stream_reader;
  localparam int DW    = 32;
  localparam int AW    = 13;
  localparam int LW    = AW + 1;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid, cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dout = '0;
  logic          m_valid, m_ready, m_last;
  logic [DW-1:0] m_data;
  logic          busy, done;
`ifdef MEM_STREAM_READER_PERF_EN
  logic [31:0]   perf_stall_cycles;
`endif

  always #5 clk = ~clk;

  mem_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_dout  (mem_dout),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .busy      (busy),
`ifdef MEM_STREAM_READER_PERF_EN
    .perf_stall_cycles (perf_stall_cycles),
`endif
    .done      (done)
  );

  // RAM port: 1-cycle read latency, no output register.
  logic [DW-1:0] ram [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i) * 32'd3;
  always @(posedge clk) if (mem_en) mem_dout <= ram[mem_addr];

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [AW-1:0] exp_addr_q [$];
  logic [DW:0]   exp_word_q [$];

  int cyc = 0;
  int en_cnt, valid_cnt, pop_cnt, done_cnt, stall_cnt, max_out;
  int first_en_cyc, last_en_cyc, first_valid_cyc, first_pop_cyc, last_pop_cyc, done_cyc;
  int accept_cyc;

  always @(posedge clk) cyc++;

  task automatic clear_stats();
    en_cnt = 0; valid_cnt = 0; pop_cnt = 0; done_cnt = 0; stall_cnt = 0; max_out = 0;
    first_en_cyc = 0; last_en_cyc = 0; first_valid_cyc = 0;
    first_pop_cyc = 0; last_pop_cyc = 0; done_cyc = 0;
  endtask

  // m_ready driver: 0 = always ready, 1 = toggling pattern, 2 = held low.
  int   ready_mode = 0;
  int   pi = 0;
  logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0: m_ready = 1'b1;
        1: begin m_ready = pat[pi % 6]; pi++; end
        default: m_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compares issued addresses and delivered words against the scoreboard.
  logic        prev_stall = 1'b0;
  logic [DW:0] prev_word  = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      logic [AW-1:0] ea;
      logic [DW:0]   ew;
      if (exp_addr_q.size() != 0 && !mem_en && !cmd_ready) stall_cnt++;
      if (mem_en) begin
        if (en_cnt == 0) first_en_cyc = cyc;
        last_en_cyc = cyc;
        en_cnt++;
        check_eq("read_expected", 64'(exp_addr_q.size() != 0), 64'd1);
        if (exp_addr_q.size() != 0) begin
          ea = exp_addr_q.pop_front();
          check_eq("mem_addr", 64'(mem_addr), 64'(ea));
        end
        check_eq("mem_we", 64'(mem_we), 64'd0);
      end
      if (m_valid) begin
        if (valid_cnt == 0) first_valid_cyc = cyc;
        valid_cnt++;
      end
      if (prev_stall) check_eq("hold_stable", 64'({m_valid, m_last, m_data}), 64'({1'b1, prev_word}));
      if (m_valid && m_ready) begin
        check_eq("word_expected", 64'(exp_word_q.size() != 0), 64'd1);
        if (exp_word_q.size() != 0) begin
          ew = exp_word_q.pop_front();
          check_eq("m_word", 64'({m_last, m_data}), 64'(ew));
        end
        if (pop_cnt == 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
        pop_cnt++;
      end
      if (en_cnt - pop_cnt > max_out) max_out = en_cnt - pop_cnt;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = m_valid && !m_ready;
      prev_word  = {m_last, m_data};
    end
  end

  task automatic send_cmd(input logic [AW-1:0] addr, input int len);
    int t = 0;
    logic [AW-1:0] a;
    logic [DW-1:0] w;
    while (!cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check_eq("cmd_ready_seen", 64'(cmd_ready), 64'd1);
    for (int i = 0; i < len; i++) begin
      a = addr + AW'(i);
      w = DW'(a) * 32'd3;
      exp_addr_q.push_back(a);
      exp_word_q.push_back({(i == len - 1), w});
    end
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_len   = LW'(len);
    @(posedge clk);
    #1;
    cmd_valid  = 1'b0;
    accept_cyc = cyc;
  endtask

  task automatic wait_done(input int max_cycles);
    int   t   = 0;
    logic got = 1'b0;
    while (t < max_cycles && !got) begin
      @(negedge clk);
      t++;
      if (done) got = 1'b1;
    end
    check_eq("done_seen", 64'(got), 64'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_flags"}, 64'({cmd_ready, mem_en, mem_we, m_valid, m_last, busy, done}),
             64'(7'b1000000));
    check_eq({tag, "_addr"}, 64'(mem_addr), 64'd0);
    check_eq({tag, "_data"}, 64'(m_data), 64'd0);
`ifdef MEM_STREAM_READER_PERF_EN
    check_eq({tag, "_perf"}, 64'(perf_stall_cycles), 64'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rt;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    clear_stats();
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_vals("post_reset");

    // Basic transfer, latency and throughput.
    clear_stats();
    send_cmd(AW'(13'h010), 4);
    wait_done(50);
    @(negedge clk);
    check_eq("done_pulse", 64'(done), 64'd0);
    check_eq("lat_en", 64'(first_en_cyc - accept_cyc), 64'd0);
    check_eq("lat_valid", 64'(first_valid_cyc - accept_cyc), 64'd1);
    check_eq("en_span", 64'(last_en_cyc - first_en_cyc), 64'd3);
    check_eq("pop_span", 64'(last_pop_cyc - first_pop_cyc), 64'd3);
    check_eq("pop_cnt1", 64'(pop_cnt), 64'd4);
    check_eq("done_lat", 64'(done_cyc - last_pop_cyc), 64'd1);
    check_eq("done_cnt1", 64'(done_cnt), 64'd1);

    // Backpressure with toggling ready.
    clear_stats();
    ready_mode = 1;
    send_cmd(AW'(13'h010), 8);
    wait_done(200);
    @(negedge clk);
    ready_mode = 0;
    check_eq("bp_pops", 64'(pop_cnt), 64'd8);
    check_eq("bp_outstanding_le2", 64'(max_out <= 2), 64'd1);
    check_eq("bp_queue_empty", 64'(exp_word_q.size()), 64'd0);
    check_eq("bp_done_cnt", 64'(done_cnt), 64'd1);

    // Zero-length command.
    clear_stats();
    send_cmd(AW'(13'h020), 0);
    repeat (5) @(negedge clk);
    check_eq("z_en", 64'(en_cnt), 64'd0);
    check_eq("z_valid", 64'(valid_cnt), 64'd0);
    check_eq("z_done_cnt", 64'(done_cnt), 64'd1);
    check_eq("z_done_lat", 64'(done_cyc - accept_cyc), 64'd0);

    // Address wrap at the top of memory.
    clear_stats();
    send_cmd(AW'(8190), 4);
    wait_done(50);
    @(negedge clk);
    check_eq("wrap_pops", 64'(pop_cnt), 64'd4);
    check_eq("wrap_addr_empty", 64'(exp_addr_q.size()), 64'd0);

    // Reset in the middle of a transfer.
    clear_stats();
    send_cmd(AW'(13'h200), 8);
    rt = 0;
    while (pop_cnt < 2 && rt < 50) begin
      @(posedge clk);
      #1;
      rt++;
    end
    check_eq("mid_pops", 64'(pop_cnt), 64'd2);
    rst = 1'b1;
    #1;
    check_reset_vals("mid_reset");
    exp_addr_q.delete();
    exp_word_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    clear_stats();
    send_cmd(AW'(13'h100), 2);
    wait_done(50);
    @(negedge clk);
    check_eq("after_rst_pops", 64'(pop_cnt), 64'd2);
    check_eq("after_rst_done", 64'(done_cnt), 64'd1);
    check_eq("after_rst_empty", 64'(exp_word_q.size()), 64'd0);

    // Back-to-back commands, second accepted in the done cycle.
    clear_stats();
    send_cmd(AW'(13'h300), 8);
    wait_done(100);
    check_eq("ready_on_done", 64'(cmd_ready), 64'd1);
`ifdef MEM_STREAM_READER_PERF_EN
    check_eq("perf_no_stall", 64'(perf_stall_cycles), 64'd0);
`endif
    send_cmd(AW'(13'h400), 8);
    check_eq("b2b_accept", 64'(accept_cyc), 64'(done_cyc + 1));
    wait_done(100);
    @(negedge clk);
    check_eq("b2b_pops", 64'(pop_cnt), 64'd16);
    check_eq("b2b_done_cnt", 64'(done_cnt), 64'd2);

`ifdef MEM_STREAM_READER_PERF_EN
    // Stall counter with the sink held off for a few cycles.
    clear_stats();
    ready_mode = 2;
    send_cmd(AW'(13'h500), 8);
    repeat (5) @(posedge clk);
    ready_mode = 0;
    wait_done(100);
    check_eq("perf_stall", 64'(perf_stall_cycles), 64'(stall_cnt));
    check_eq("perf_nonzero", 64'(stall_cnt > 0), 64'd1);
    @(negedge clk);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
